// File: rtl/sram_arb.sv
// sram_arb: two-master round-robin arbiter placed directly in front of the
// SRAM controller. It merges the instruction-fetch port (m0) and the
// load/store port (m1) onto the controller's single stb/ack port. The
// granted request is captured and held until the controller acks. The
// master then gets a registered ack plus read data, and one idle cycle
// is inserted before the next downstream strobe.
module sram_arb #(
  parameter int ADDR_W      = 21,
  parameter bit FIRST_GRANT = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // master 0 (instruction fetch)
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [3:0]        i_m0_we,
  input  logic [31:0]       i_m0_dat_w,
  input  logic              i_m0_stb,
  output logic              o_m0_ack,
  output logic [31:0]       o_m0_dat_r,
  // master 1 (load/store)
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [3:0]        i_m1_we,
  input  logic [31:0]       i_m1_dat_w,
  input  logic              i_m1_stb,
  output logic              o_m1_ack,
  output logic [31:0]       o_m1_dat_r,
  // SRAM controller request port
  output logic [ADDR_W-1:0] o_addr,
  output logic [3:0]        o_we,
  output logic [31:0]       o_dat_w,
  output logic              o_stb,
  input  logic              i_ack,
  input  logic [31:0]       i_dat_r
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE,
    ST_GAP
  } state_t;

  state_t            state_q;
  logic              last_grant_q;   // master served most recently
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        we_q;
  logic [31:0]       dat_w_q;
  logic              stb_q;
  logic              m0_ack_q;
  logic              m1_ack_q;
  logic [31:0]       m0_dat_r_q;
  logic [31:0]       m1_dat_r_q;

  logic              grant_d;
  logic              sel_d;
  logic [ADDR_W-1:0] addr_d;
  logic [3:0]        we_d;
  logic [31:0]       dat_w_d;

  // Arbitration decision and the request fields of the selected master.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    grant_d = 1'b0;
    sel_d   = ~last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (i_m0_stb && i_m1_stb) begin
          grant_d = 1'b1;
          sel_d   = ~last_grant_q;
        end else if (i_m0_stb) begin
          grant_d = 1'b1;
          sel_d   = 1'b0;
        end else if (i_m1_stb) begin
          grant_d = 1'b1;
          sel_d   = 1'b1;
        end
      end
      // The just-served master may still hold stb from its ack cycle.
      // Only the other master is eligible here.
      ST_GAP:  grant_d = last_grant_q ? i_m0_stb : i_m1_stb;
      default: grant_d = 1'b0;
    endcase
    addr_d  = sel_d ? i_m1_addr  : i_m0_addr;
    we_d    = sel_d ? i_m1_we    : i_m0_we;
    dat_w_d = sel_d ? i_m1_dat_w : i_m0_dat_w;
  end

  // FSM with registered request, strobe, acks and per-master read data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ~FIRST_GRANT;
      addr_q       <= '0;
      we_q         <= '0;
      dat_w_q      <= '0;
      stb_q        <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_dat_r_q   <= '0;
      m1_dat_r_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // pre-edge values. The acks default low here, so they can only pulse
      // for a single cycle.
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_GAP: begin
          if (grant_d) begin
            addr_q       <= addr_d;
            we_q         <= we_d;
            dat_w_q      <= dat_w_d;
            stb_q        <= 1'b1;
            last_grant_q <= sel_d;
            state_q      <= ST_BUSY;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (i_ack) begin
            stb_q <= 1'b0;
            if (last_grant_q) begin
              m1_ack_q   <= 1'b1;
              m1_dat_r_q <= i_dat_r;
            end else begin
              m0_ack_q   <= 1'b1;
              m0_dat_r_q <= i_dat_r;
            end
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_GAP;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_addr     = addr_q;
  assign o_we       = we_q;
  assign o_dat_w    = dat_w_q;
  assign o_stb      = stb_q;
  assign o_m0_ack   = m0_ack_q;
  assign o_m1_ack   = m1_ack_q;
  assign o_m0_dat_r = m0_dat_r_q;
  assign o_m1_dat_r = m1_dat_r_q;

endmodule
